// File: rtl/div_pkg.sv
// Shared FSM encoding and default operand width for the iterative divider.
// DIV_ZERO_FAST_EN adds the ZERO state used by the divide-by-zero shortcut.
package div_pkg;

    localparam int DIV_WIDTH = 32;

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ZERO = 2'd3
    } divState_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_t;
`endif

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and produces one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The extra top bit of diff is the borrow: set means the trial subtract failed.
    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        remOut  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quoOut  = {quoIn[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit with pipeline stall handshake; result = {rem, quo}.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero in two cycles via ZERO.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic               stall_div,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    divState_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic             sgnReg;
    logic             negRem;
    logic             negQuo;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic             accept;

    function automatic logic [WIDTH-1:0] absMag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fixSign(
        input logic [WIDTH-1:0] rawRem,
        input logic [WIDTH-1:0] rawQuo,
        input logic             isSigned,
        input logic             negR,
        input logic             negQ
    );
        logic [WIDTH-1:0] remF;
        logic [WIDTH-1:0] quoF;
        remF = (isSigned && negR) ? -rawRem : rawRem;
        quoF = (isSigned && negQ) ? -rawQuo : rawQuo;
        return {remF, quoF};
    endfunction

    assign accept = (state == IDLE) && start && !cancel;

    div_step #(.WIDTH(WIDTH)) uStep (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorReg),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    // Operand and partial-result registers carry no reset; only control is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            quoReg     <= signed_div ? absMag(a) : a;
            divisorReg <= signed_div ? absMag(b) : b;
            remReg     <= '0;
            sgnReg     <= signed_div;
            negRem     <= a[WIDTH-1];
            negQuo     <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (state == RUN) begin
            remReg <= stepRem;
            quoReg <= stepQuo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else if (cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
`ifdef DIV_ZERO_FAST_EN
                        state <= (b == '0) ? ZERO : RUN;
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // The last step's output goes straight through the sign fix-up.
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        result <= fixSign(stepRem, stepQuo, sgnReg, negRem, negQuo);
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                ZERO: begin
                    // Same answer the full run would give: quotient all ones, remainder |a|.
                    state  <= DONE;
                    result <= fixSign(quoReg, {WIDTH{1'b1}}, sgnReg, negRem, negQuo);
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == DONE) && !cancel;

    assign stall_div = rst && (accept || (state == RUN)
`ifdef DIV_ZERO_FAST_EN
                               || (state == ZERO)
`endif
                              );

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; the result is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  a divide instruction is present in the execute stage.
REQ-005 SHALL have port signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port cancel  input  1  flushE or exception; aborts the operation.
REQ-009 SHALL have port stall_div  output  1  pipeline stall request to the hazard unit.
REQ-010 SHALL have port ready  output  1  one-cycle pulse: result is valid.
REQ-011 SHALL have port result  output  2*WIDTH  {hi = remainder, lo = quotient}, routed to the HI/LO write path.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE, plus ZERO when DIV_ZERO_FAST_EN is defined.
REQ-013 SHALL define t0 as the cycle in which the FSM is in IDLE, start = 1 and cancel = 0.
REQ-014 SHALL, at t0, latch |a| and |b| (magnitudes taken only when signed_div = 1), the sign of a, sign(a) XOR sign(b), and signed_div; clear the iteration counter; and go to RUN.
REQ-015 SHALL, in RUN, perform one restoring shift-subtract step per cycle, WIDTH steps in total, occupying cycles t0+1 .. t0+WIDTH.
REQ-016 SHALL be in DONE at cycle t0+WIDTH+1, assert ready for exactly that cycle, and return to IDLE on the next cycle.
REQ-017 SHALL drive stall_div = (IDLE & start & ~cancel) | RUN | ZERO, combinationally; stall_div SHALL be 0 in DONE so the instruction retires there.
REQ-018 SHALL ignore start while in RUN, ZERO or DONE.
REQ-019 SHALL, when latched signed_div = 1, negate the quotient if the sign XOR is 1, and negate the remainder if the dividend was negative; the fix-up is applied at entry to DONE.
REQ-020 SHALL hold result stable from DONE until the next DONE.
REQ-021 SHALL, when b = 0 and DIV_ZERO_FAST_EN is not defined, run the normal WIDTH-cycle path; the result is the natural restoring output (unsigned: lo = all ones, hi = a).
REQ-022 SHALL, on cancel = 1 in any state, go to IDLE on the next edge, suppress ready, and leave result unchanged.
REQ-023 SHALL, when cancel and start are both high in IDLE, not start an operation.

Reset
REQ-024 SHALL, when rst is low, asynchronously force state = IDLE, counter = 0, result = 0 and ready = 0, including mid-operation.
REQ-025 SHALL drive stall_div = 0 during reset regardless of start.

Configuration
REQ-026 SHALL, when DIV_ZERO_FAST_EN is defined and b = 0 at t0, go to ZERO instead of RUN; ZERO then enters DONE at t0+2, with ready at t0+2.
REQ-027 SHALL, in the ZERO path, produce a result bit-identical to the non-macro path: hi = a; lo = 1 if (signed_div & a[WIDTH-1]), else all ones.
REQ-028 SHALL, without DIV_ZERO_FAST_EN, have no ZERO state and no zero-detect logic.

Structure
REQ-029 SHALL take the state enum and the default WIDTH constant from shared package div_pkg.
REQ-030 SHALL place one restoring step (remainder/quotient in, remainder/quotient out) in a combinational sub-module div_step, instantiated once.

Verification
REQ-031 SHALL cover: a = 100, b = 7, DIVU -> ready at t0+33, lo = 14, hi = 2; stall_div high over t0..t0+32.
REQ-032 SHALL cover: a = -7, b = 2, DIV -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-033 SHALL cover: a = 50, b = 5 started, then cancel at t0+10 -> IDLE at t0+11, no ready pulse, result unchanged, stall_div = 0 at t0+11.
REQ-034 SHALL cover: b = 0, a = -8, DIV -> lo = 1, hi = 0xFFFFFFF8; ready at t0+33 without the macro and at t0+2 with it.
REQ-035 SHALL cover: rst pulsed low at t0+5 -> immediate IDLE, result = 0; a new start afterwards completes correctly.
REQ-036 SHALL cover: two back-to-back divides, the second start arriving the cycle after DONE -> both results correct, ready pulses 34 cycles apart.
